vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing source that drives the color mapper's pixel interface.
//  Divides the system clock into a pixel-rate enable and runs horizontal/vertical counters,
//  producing DrawX/DrawY, the active-video flag (blank), hs/vs and a once-per-frame tick for game logic.
//  hs/vs/blank are delayed to line up with the color mapper's one-cycle registered RGB output.
// PARAMETERS
//  CLK_DIV     2    system clocks per pixel (>=1); 50 MHz -> 25 MHz pixel rate
//  H_VISIBLE   640  visible pixels per line
//  H_FP        16   horizontal front porch, pixels
//  H_SYNC      96   horizontal sync width, pixels
//  H_BP        48   horizontal back porch, pixels
//  V_VISIBLE   480  visible lines per frame
//  V_FP        10   vertical front porch, lines
//  V_SYNC      2    vertical sync width, lines
//  V_BP        33   vertical back porch, lines
//  SYNC_DELAY  1    pixel ticks of delay on hs/vs/blank relative to DrawX/DrawY (0..3)
// PORTS
//  CLK        in   1   system clock; all state on rising edge
//  Reset_n    in   1   asynchronous active-low reset
//  pixel_clk  out  1   pixel enable: high for 1 CLK cycle in every CLK_DIV cycles
//  DrawX      out  10  current column, 0..H_TOTAL-1
//  DrawY      out  10  current line, 0..V_TOTAL-1
//  blank      out  1   1 = visible region (color mapper draws), 0 = blanking; delayed SYNC_DELAY
//  hs         out  1   horizontal sync, active low; delayed SYNC_DELAY
//  vs         out  1   vertical sync, active low; delayed SYNC_DELAY
//  frame_clk  out  1   1-CLK pulse at start of vertical blanking; game-state update tick
// BEHAVIOUR
//  - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
//  - Reset (Reset_n=0, async): div counter=0, hc=0, vc=0, delay pipes filled with blanking values;
//    outputs pixel_clk=0, DrawX=0, DrawY=0, blank=0, hs=1, vs=1, frame_clk=0. Hold while low.
//  - Divider: counter 0..CLK_DIV-1, wraps; pixel_clk=1 in the CLK cycle where counter==CLK_DIV-1.
//    CLK_DIV=1 -> pixel_clk constantly 1 after reset release. First pixel_clk CLK_DIV cycles after release.
//  - Counters advance only on pixel_clk: hc+1; at hc==H_TOTAL-1 hc->0 and vc+1;
//    at hc==H_TOTAL-1 && vc==V_TOTAL-1 both -> 0 (frame wrap). No other wrap values.
//  - DrawX=hc, DrawY=vc, registered, no delay; change on the CLK edge following pixel_clk.
//  - Undelayed decode from (hc,vc):
//    act = hc<H_VISIBLE && vc<V_VISIBLE;
//    hs_r = !(hc>=H_VISIBLE+H_FP && hc<H_VISIBLE+H_FP+H_SYNC)   (low for hc 656..751);
//    vs_r = !(vc>=V_VISIBLE+V_FP && vc<V_VISIBLE+V_FP+V_SYNC)   (low for vc 490..491).
//  - blank/hs/vs = act/hs_r/vs_r passed through SYNC_DELAY pixel-enabled register stages
//    (shift only on pixel_clk); SYNC_DELAY=0 -> registered decode of current counters.
//  - frame_clk=1 for exactly one CLK cycle: the cycle after counters step to (hc=0, vc=V_VISIBLE).
//    Never asserted twice per frame; not asserted during reset.
//  - Arithmetic: counters 10 bits, unsigned; comparisons unsigned; parameter sums must be <1024.
//  - Reset mid-frame: all state returns to reset values immediately; next frame starts at (0,0), no partial
//    frame_clk.
// TESTING
//  1 Reset: hold Reset_n=0 20 CLK, release -> DrawX=0,DrawY=0,hs=1,vs=1,blank=0; pixel_clk first high on CLK 2.
//  2 Line: run 800 pixel ticks -> DrawX 0..799 then 0, DrawY 0->1; hs low exactly 96 ticks, starting 1 tick
//    after DrawX=656 (SYNC_DELAY=1).
//  3 Frame: run 800*525 ticks -> DrawY wraps 524->0; vs low exactly 1600 ticks; one frame_clk per frame, at
//    (0,480).
//  4 Blank: check blank=1 for 640*480=307200 ticks per frame, first blank=1 tick after (0,0) with SYNC_DELAY=1.
//  5 Async reset at DrawX=700,DrawY=300 mid-CLK -> outputs reset at once without a clock edge; restart from (0,0).
//  6 Params: CLK_DIV=1, SYNC_DELAY=0, small totals (H 8+2+2+2, V 4+1+1+1) -> pixel_clk stuck 1; hs/vs/blank
//    match decode.

Source files
------------

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Pixel-rate divider plus raster counters producing DrawX/DrawY,
//            delayed blank/hs/vs and a once-per-frame game tick.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int CLK_DIV    = 2,
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 1
) (
    input  logic       CLK,
    input  logic       Reset_n,
    output logic       pixel_clk,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_clk
);

    localparam int               c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       c_H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0]       c_HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0]       c_HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0]       c_H_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]       c_V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0]       c_VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0]       c_VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [9:0]       c_V_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    // {act, hs, vs} as seen during blanking
    localparam logic [2:0]       c_BLANKING = 3'b011;

    logic [c_DIV_W-1:0] r_div;
    logic               r_pix;
    logic [9:0]         r_hc;
    logic [9:0]         r_vc;
    logic               r_frame;
    logic [2:0]         r_pipe [0:SYNC_DELAY];

    logic [9:0]         w_hc_nxt;
    logic [9:0]         w_vc_nxt;
    logic [2:0]         w_dec_nxt;

    always_comb begin
        w_hc_nxt = r_hc;
        w_vc_nxt = r_vc;
        if (r_pix) begin
            if (r_hc == c_H_LAST) begin
                w_hc_nxt = 10'd0;
                w_vc_nxt = (r_vc == c_V_LAST) ? 10'd0 : r_vc + 10'd1;
            end else begin
                w_hc_nxt = r_hc + 10'd1;
            end
        end
    end

    // Decoding the post-edge counters keeps stage 0 aligned with DrawX/DrawY.
    always_comb begin
        w_dec_nxt[2] = (w_hc_nxt < c_H_VIS) && (w_vc_nxt < c_V_VIS);
        w_dec_nxt[1] = !((w_hc_nxt >= c_HS_START) && (w_hc_nxt < c_HS_END));
        w_dec_nxt[0] = !((w_vc_nxt >= c_VS_START) && (w_vc_nxt < c_VS_END));
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_div   <= '0;
            r_pix   <= 1'b0;
            r_hc    <= 10'd0;
            r_vc    <= 10'd0;
            r_frame <= 1'b0;
        end else begin
            r_div   <= (r_div == c_DIV_LAST) ? '0 : r_div + c_DIV_W'(1);
            r_pix   <= (r_div == c_DIV_LAST);
            r_hc    <= w_hc_nxt;
            r_vc    <= w_vc_nxt;
            r_frame <= r_pix && (w_hc_nxt == 10'd0) && (w_vc_nxt == c_V_VIS);
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i <= SYNC_DELAY; i++) begin
                r_pipe[i] <= c_BLANKING;
            end
        end else begin
            r_pipe[0] <= w_dec_nxt;
            if (r_pix) begin
                for (int i = 1; i <= SYNC_DELAY; i++) begin
                    r_pipe[i] <= r_pipe[i-1];
                end
            end
        end
    end

    assign pixel_clk = r_pix;
    assign DrawX     = r_hc;
    assign DrawY     = r_vc;
    assign blank     = r_pipe[SYNC_DELAY][2];
    assign hs        = r_pipe[SYNC_DELAY][1];
    assign vs        = r_pipe[SYNC_DELAY][0];
    assign frame_clk = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Scoreboard bench for vga_timing_gen across four parameter sets,
//            with random run lengths and mid-cycle asynchronous resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pix;
        logic [9:0] x;
        logic [9:0] y;
        logic       blank;
        logic       hs;
        logic       vs;
        logic       frame;
    } obs_t;

    logic CLK;
    logic Reset_n;

    logic       pix0, pix1, pix2, pix3;
    logic [9:0] x0, x1, x2, x3, y0, y1, y2, y3;
    logic       b0, b1, b2, b3, h0, h1, h2, h3, v0, v1, v2, v3, f0, f1, f2, f3;

    obs_t got [4];
    obs_t q [4][$];

    int checks = 0;
    int errors = 0;
    int c      = 0;
    bit in_rst = 1'b1;

    vga_timing_gen #(.CLK_DIV(2), .H_VISIBLE(40), .H_FP(4), .H_SYNC(6), .H_BP(5),
                     .V_VISIBLE(20), .V_FP(2), .V_SYNC(3), .V_BP(4), .SYNC_DELAY(1)) dut0 (
        .CLK(CLK), .Reset_n(Reset_n), .pixel_clk(pix0), .DrawX(x0), .DrawY(y0),
        .blank(b0), .hs(h0), .vs(v0), .frame_clk(f0));

    vga_timing_gen #(.CLK_DIV(1), .H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                     .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_DELAY(0)) dut1 (
        .CLK(CLK), .Reset_n(Reset_n), .pixel_clk(pix1), .DrawX(x1), .DrawY(y1),
        .blank(b1), .hs(h1), .vs(v1), .frame_clk(f1));

    vga_timing_gen #(.CLK_DIV(3), .H_VISIBLE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
                     .V_VISIBLE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_DELAY(3)) dut2 (
        .CLK(CLK), .Reset_n(Reset_n), .pixel_clk(pix2), .DrawX(x2), .DrawY(y2),
        .blank(b2), .hs(h2), .vs(v2), .frame_clk(f2));

    vga_timing_gen dut3 (
        .CLK(CLK), .Reset_n(Reset_n), .pixel_clk(pix3), .DrawX(x3), .DrawY(y3),
        .blank(b3), .hs(h3), .vs(v3), .frame_clk(f3));

    assign got[0] = {pix0, x0, y0, b0, h0, v0, f0};
    assign got[1] = {pix1, x1, y1, b1, h1, v1, f1};
    assign got[2] = {pix2, x2, y2, b2, h2, v2, f2};
    assign got[3] = {pix3, x3, y3, b3, h3, v3, f3};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Closed-form raster position after c clock edges since reset release.
    function automatic obs_t model(int cyc, int div, int hv, int hfp, int hsw, int hbp,
                                   int vv, int vfp, int vsw, int vbp, int dly);
        int   ht = hv + hfp + hsw + hbp;
        int   vt = vv + vfp + vsw + vbp;
        int   k, kd, hx, vy;
        obs_t o;
        o = '{pix: 1'b0, x: 10'd0, y: 10'd0, blank: 1'b0, hs: 1'b1, vs: 1'b1, frame: 1'b0};
        if (cyc == 0) return o;
        o.pix = ((cyc % div) == 0);
        k     = (cyc - 1) / div;
        o.x   = 10'(k % ht);
        o.y   = 10'((k / ht) % vt);
        kd    = k - dly;
        if (kd >= 0) begin
            hx      = kd % ht;
            vy      = (kd / ht) % vt;
            o.blank = (hx < hv) && (vy < vv);
            o.hs    = !((hx >= hv + hfp) && (hx < hv + hfp + hsw));
            o.vs    = !((vy >= vv + vfp) && (vy < vv + vfp + vsw));
        end
        o.frame = (cyc >= 2) && (((cyc - 1) % div) == 0) && (k % ht == 0)
                  && ((k / ht) % vt == vv);
        return o;
    endfunction

    function automatic obs_t exp_obs(int id, int cyc);
        case (id)
            0:       return model(cyc, 2, 40, 4, 6, 5, 20, 2, 3, 4, 1);
            1:       return model(cyc, 1, 8, 2, 2, 2, 4, 1, 1, 1, 0);
            2:       return model(cyc, 3, 20, 3, 4, 5, 10, 2, 2, 3, 3);
            default: return model(cyc, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1);
        endcase
    endfunction

    task automatic tick_push();
        @(posedge CLK);
        if (!in_rst) c++;
        for (int i = 0; i < 4; i++) q[i].push_back(exp_obs(i, in_rst ? 0 : c));
    endtask

    task automatic run(int n);
        repeat (n) tick_push();
    endtask

    // Reset lands between edges; the pending expectation is replaced by reset values.
    task automatic async_reset(int hold);
        int dly;
        tick_push();
        dly = $urandom_range(1, 4);
        #(dly);
        Reset_n = 1'b0;
        in_rst  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            q[i].push_back(exp_obs(i, 0));
        end
        run(hold);
        @(negedge CLK);
        Reset_n = 1'b1;
        in_rst  = 1'b0;
        c       = 0;
    endtask

    initial begin
        @(posedge CLK);
        forever begin
            @(negedge CLK);
            for (int i = 0; i < 4; i++) begin
                obs_t e;
                checks++;
                if (q[i].size() == 0) begin
                    errors++;
                    $display("FAIL dut%0d scoreboard_empty at t=%0t", i, $time);
                end else begin
                    e = q[i].pop_front();
                    if (got[i] !== e) begin
                        errors++;
                        $display("FAIL dut%0d t=%0t got pix=%0b x=%0d y=%0d blank=%0b hs=%0b vs=%0b frame=%0b exp pix=%0b x=%0d y=%0d blank=%0b hs=%0b vs=%0b frame=%0b",
                                 i, $time, got[i].pix, got[i].x, got[i].y, got[i].blank,
                                 got[i].hs, got[i].vs, got[i].frame, e.pix, e.x, e.y,
                                 e.blank, e.hs, e.vs, e.frame);
                    end
                end
            end
        end
    end

    initial begin
        Reset_n = 1'b0;
        in_rst  = 1'b1;
        run(20);
        @(negedge CLK);
        Reset_n = 1'b1;
        in_rst  = 1'b0;
        c       = 0;
        run(3400);
        for (int r = 0; r < 6; r++) begin
            run($urandom_range(50, 2500));
            async_reset($urandom_range(1, 8));
        end
        run(7000);
        @(negedge CLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
